// File: rtl/pito_apb_hart_arbiter.sv
// pito_apb_hart_arbiter
// Serialises per-hart CSR requests onto one shared APB master port.
// Harts are granted round-robin, one transfer in flight at a time. Each grant
// runs a full SETUP/ACCESS transfer. Read data and error status then go back
// to the granted hart as a one-cycle response pulse. An ACCESS phase with no
// pready for TIMEOUT cycles is forced to complete with an error.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   req_valid/addr/wdata/write  per-hart request (addr/wdata packed 32 bits per hart)
//   req_ready                one-hot grant pulse (combinational in IDLE)
//   rsp_valid                one-hot completion pulse
//   rsp_rdata, rsp_err       response payload, held until the next completion
//   paddr/pwdata/pwrite/pstrb/psel/penable   APB master outputs
//   prdata/pready/pslverr    APB slave responses
module pito_apb_hart_arbiter #(
    parameter int NUM_HARTS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_HARTS-1:0]    req_valid,
    input  logic [32*NUM_HARTS-1:0] req_addr,
    input  logic [32*NUM_HARTS-1:0] req_wdata,
    input  logic [NUM_HARTS-1:0]    req_write,
    output logic [NUM_HARTS-1:0]    req_ready,
    output logic [NUM_HARTS-1:0]    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [31:0]             paddr,
    output logic [31:0]             pwdata,
    output logic                    pwrite,
    output logic [3:0]              pstrb,
    output logic                    psel,
    output logic                    penable,
    input  logic [31:0]             prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int HW = $clog2(NUM_HARTS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] rr_ptr, hart_q;
    logic [HW-1:0] gnt_idx, probe;
    logic          gnt_found;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          write_q, err_q;
    logic [15:0]   cnt;
    logic          timeout_hit;

    // cnt holds the number of ACCESS cycles already completed, so the
    // TIMEOUT-th cycle is the one that sees cnt == TIMEOUT-1.
    assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

    // Round-robin pick: scan offsets from the highest down so the last hit is
    // the lowest offset from rr_ptr. The index wraps because NUM_HARTS is a
    // power of two.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        probe     = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            probe = rr_ptr + HW'(i);
            if (req_valid[probe]) begin
                gnt_found = 1'b1;
                gnt_idx   = probe;
            end
        end
    end

    // Next state and grant. Grants are suppressed while rst is high so that
    // every output reads 0 during reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_found && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_nxt          = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            hart_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        hart_q  <= gnt_idx;
                        addr_q  <= req_addr[{gnt_idx, 5'b0} +: 32];
                        wdata_q <= req_wdata[{gnt_idx, 5'b0} +: 32];
                        write_q <= req_write[gnt_idx];
                        rr_ptr  <= gnt_idx + HW'(1);
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 16'd1;
                    // pready takes priority over a timeout in the same cycle.
                    if (pready) begin
                        rdata_q <= write_q ? 32'h0 : prdata;
                        err_q   <= pslverr;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The APB outputs are decoded from state, so an async reset drops
    // psel/penable immediately.
    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);
    assign paddr   = psel ? addr_q  : 32'h0;
    assign pwdata  = psel ? wdata_q : 32'h0;
    assign pwrite  = psel & write_q;
    assign pstrb   = psel ? 4'hF : 4'h0;

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[hart_q] = 1'b1;
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_pito_apb_hart_arbiter.sv
// Self-checking bench for pito_apb_hart_arbiter (8 harts, TIMEOUT=4).
// A table of single-hart transfers covers reads, writes, wait states, slave
// errors, timeout, and pready arriving on the last allowed cycle. Hand-written
// sequences cover round-robin order and reset during a transfer.
module tb_pito_apb_hart_arbiter;

    localparam int NH  = 8;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NH-1:0]   req_valid;
    logic [32*NH-1:0] req_addr, req_wdata;
    logic [NH-1:0]   req_write, req_ready, rsp_valid;
    logic [31:0]     rsp_rdata, paddr, pwdata, prdata;
    logic            rsp_err, pwrite, psel, penable, pready, pslverr;
    logic [3:0]      pstrb;

    int ncmp = 0;
    int nerr = 0;

    pito_apb_hart_arbiter #(.NUM_HARTS(NH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pstrb(pstrb),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          hart;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] prd;
        logic        slverr;
        int          waits;      // pready-low ACCESS cycles before pready
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One transfer from a single requesting hart. The number of ACCESS
    // cycles is waits+1, capped at TMO when pready never arrives in time.
    task automatic do_xfer(input vec_t v);
        int acc;
        acc = (v.waits >= TMO) ? TMO : v.waits + 1;
        @(negedge clk);
        req_valid = '0;
        req_valid[v.hart] = 1'b1;
        req_write[v.hart] = v.wr;
        req_addr[v.hart*32 +: 32]  = v.addr;
        req_wdata[v.hart*32 +: 32] = v.wdata;
        #1 chk("grant", 32'(req_ready), 32'(1) << v.hart);
        @(negedge clk);
        req_valid = '0;
        chk("setup_sel_en", {30'b0, psel, penable}, 32'h2);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
        chk("setup_pstrb", 32'(pstrb), 32'hF);
        for (int k = 0; k < acc; k++) begin
            @(negedge clk);
            chk("access_sel_en", {30'b0, psel, penable}, 32'h3);
            chk("access_pwdata", pwdata, v.wdata);
            pready  = (k >= v.waits);
            prdata  = v.prd;
            pslverr = v.slverr;
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << v.hart);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("resp_psel", 32'(psel), 32'h0);
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'h0);
        chk("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{3, 32'h0000_0100, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 0,  32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1, 32'h0000_0040, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 1'b1, 3,  32'h0,         1'b1};
        vecs[2] = '{5, 32'h0000_0200, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 3,  32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{0, 32'h0000_0300, 32'h0,         1'b0, 32'h1111_1111, 1'b0, 99, 32'h0,         1'b1};
        vecs[4] = '{7, 32'h0000_07FC, 32'h0BAD_C0DE, 1'b1, 32'hFFFF_FFFF, 1'b0, 1,  32'h0,         1'b0};
        vecs[5] = '{2, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h8000_0001, 1'b1, 0,  32'h8000_0001, 1'b1};

        rst = 1'b1;
        req_valid = '1; req_addr = '0; req_wdata = '0; req_write = '0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

        // Reset state: every output is 0, even with requests pending.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_apb", {paddr[15:0], pwdata[11:0], pstrb}, 32'h0);
        chk("rst_ctrl", {29'b0, pwrite, psel, penable}, 32'h0);
        req_valid = '0;
        rst = 1'b0;

        // Round robin: all harts request at once, one grant every 4 cycles.
        @(negedge clk);
        pready = 1'b1; prdata = 32'h5555_0000;
        req_valid = '1;
        for (int g = 0; g < NH; g++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(1) << g);
            @(negedge clk);
            req_valid[g] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp", 32'(rsp_valid), 32'(1) << g);
            @(negedge clk);
        end
        // rr_ptr has wrapped to 0: harts 2 and 5 go in that order.
        req_valid = 8'h24;
        #1 chk("rr_grant_2", 32'(req_ready), 32'h04);
        @(negedge clk); req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("rr_grant_5", 32'(req_ready), 32'h20);
        @(negedge clk); req_valid[5] = 1'b0;
        repeat (3) @(negedge clk);
        pready = 1'b0; prdata = 32'h0;

        foreach (vecs[i]) do_xfer(vecs[i]);

        // Reset during ACCESS: bus drops at once and no response is issued.
        @(negedge clk);
        req_valid = 8'h40;
        #1 chk("mid_grant6", 32'(req_ready), 32'h40);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        chk("mid_access", {30'b0, psel, penable}, 32'h3);
        #2 rst = 1'b1;
        #1 chk("mid_rst_bus", {30'b0, psel, penable}, 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("mid_rst_rsp2", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        // rr_ptr is back to 0, so hart 3 wins over hart 7.
        req_valid = 8'h88;
        pready = 1'b1; prdata = 32'h3333_3333;
        #1 chk("post_rst_grant", 32'(req_ready), 32'h08);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_rsp", 32'(rsp_valid), 32'h08);
        chk("post_rst_rdata", rsp_rdata, 32'h3333_3333);
        @(negedge clk);
        pready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
